// File: rtl/pwm_duty_gen.sv
// pwm_duty_gen: programmable period/high-time waveform generator.
// Configuration is double-buffered. A pending pair is captured on cfg_load.
// The pending pair moves to the active pair only at a period boundary, so
// every emitted period has exactly one duty cycle.
//
// Handshake: cfg_load is a single-cycle strobe with no ready/back-pressure.
// A legal load (period_in >= 2) always lands in the pending pair on that edge.
// An illegal load is dropped, and it is reported by a one-cycle cfg_err pulse
// on the following cycle.
module pwm_duty_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             pwm_out,
    output logic             period_start,
    output logic             cfg_err,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] pend_per_q, pend_hi_q;
    logic [WIDTH-1:0] act_per_q, act_hi_q;
    logic             pwm_q, ps_q, err_q, busy_q;

    logic             cfg_ok;
    logic [WIDTH-1:0] pend_per_d, pend_hi_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;

    // Pending pair as it will be after this edge; a load coinciding with a
    // load point is therefore the value that gets transferred to active.
    always_comb begin
        cfg_ok     = cfg_load && (period_in >= WIDTH'(2));
        pend_per_d = cfg_ok ? period_in : pend_per_q;
        pend_hi_d  = cfg_ok ? high_in   : pend_hi_q;
        cnt_inc    = cnt_q + WIDTH'(1);
        wrap       = (cnt_q == (act_per_q - WIDTH'(1)));
    end

    // Main FSM with registered outputs. At a wrap, RUN and DRAIN behave the
    // same: en decides between starting a new period and returning to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_per_q <= WIDTH'(2);
            pend_hi_q  <= WIDTH'(1);
            act_per_q  <= WIDTH'(2);
            act_hi_q   <= WIDTH'(1);
            pwm_q      <= 1'b0;
            ps_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pend_per_q <= pend_per_d;
            pend_hi_q  <= pend_hi_d;
            err_q      <= cfg_load && !cfg_ok;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (en) begin
                        state_q   <= RUN;
                        act_per_q <= pend_per_d;
                        act_hi_q  <= pend_hi_d;
                        pwm_q     <= (pend_hi_d != '0);
                        ps_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        pwm_q  <= 1'b0;
                        ps_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (en) begin
                            state_q   <= RUN;
                            act_per_q <= pend_per_d;
                            act_hi_q  <= pend_hi_d;
                            pwm_q     <= (pend_hi_d != '0);
                            ps_q      <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            pwm_q   <= 1'b0;
                            ps_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= en ? RUN : DRAIN;
                        cnt_q   <= cnt_inc;
                        pwm_q   <= (cnt_inc < act_hi_q);
                        ps_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pwm_q   <= 1'b0;
                    ps_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign cfg_err      = err_q;
    assign busy         = busy_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: table vectors, hand-written corner sequences and a
// randomized run against a period-level reference model.
module tb_pwm_duty_gen;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, cfg_load;
    logic [W-1:0] period_in, high_in;
    logic         pwm_out, period_start, cfg_err, busy;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    pwm_duty_gen #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_load     (cfg_load),
        .period_in    (period_in),
        .high_in      (high_in),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .cfg_err      (cfg_err),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // exp_q holds the {pwm, period_start} samples still to come in the
    // current period. When it runs dry a period has ended and en decides
    // whether a whole new period (from the pending pair) is queued.
    logic [1:0]   exp_q[$];
    logic         m_run;
    logic [W-1:0] m_pend_per, m_pend_hi;
    logic         m_pwm, m_ps, m_err;

    function automatic void model_reset();
        exp_q.delete();
        m_run      = 1'b0;
        m_pend_per = 8'd2;
        m_pend_hi  = 8'd1;
        m_pwm      = 1'b0;
        m_ps       = 1'b0;
        m_err      = 1'b0;
    endfunction

    function automatic void model_edge(input logic e, input logic ld,
                                       input logic [W-1:0] p, input logic [W-1:0] h);
        m_err = ld && (p < 2);
        if (ld && p >= 2) begin
            m_pend_per = p;
            m_pend_hi  = h;
        end
        if (m_run && exp_q.size() > 0) begin
            {m_pwm, m_ps} = exp_q.pop_front();
        end else if (e) begin
            for (int i = 0; i < int'(m_pend_per); i++)
                exp_q.push_back({(i < int'(m_pend_hi)), (i == 0)});
            {m_pwm, m_ps} = exp_q.pop_front();
            m_run = 1'b1;
        end else begin
            m_run = 1'b0;
            m_pwm = 1'b0;
            m_ps  = 1'b0;
        end
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check1({tag, ".pwm"},  pwm_out,      m_pwm);
        check1({tag, ".ps"},   period_start, m_ps);
        check1({tag, ".busy"}, busy,         m_run);
        check1({tag, ".err"},  cfg_err,      m_err);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: drive inputs, take one rising edge, update the
    // model, and return at the following negedge ready for sampling.
    task automatic tick(input logic e, input logic ld,
                        input logic [W-1:0] p, input logic [W-1:0] h);
        en        = e;
        cfg_load  = ld;
        period_in = p;
        high_in   = h;
        @(posedge clk);
        model_edge(e, ld, p, h);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 8'd0, 8'd0);
            check_model(tag);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_load  = 1'b0;
        period_in = '0;
        high_in   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        check_int("reset.state", int'(dbg_state), 0);
        rst_n = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic         en;
        logic         ld;
        logic [W-1:0] per;
        logic [W-1:0] hi;
        logic         pwm;
        logic         ps;
        logic         busy;
        logic         err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input logic e, input logic ld, input logic [W-1:0] p,
                                    input logic [W-1:0] h, input logic ep, input logic eps,
                                    input logic eb, input logic ee);
        vec_t v;
        v.en = e; v.ld = ld; v.per = p; v.hi = h;
        v.pwm = ep; v.ps = eps; v.busy = eb; v.err = ee;
        tbl.push_back(v);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [11:0] sh;
        real t0, t_fall, t1;
        logic en_r;

        // Default 2/1 toggling, stop, 25% run, rejected load.
        for (int i = 0; i < 10; i++)
            add_vec(1, 0, 0, 0, (i % 2 == 0), (i % 2 == 0), 1, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add_vec(1, 0, 0, 0, (i % 4 == 0), (i % 4 == 0), 1, 0);
        add_vec(1, 1, 1, 0, 1, 1, 1, 1);
        add_vec(1, 0, 0, 0, 0, 0, 1, 0);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].en, tbl[i].ld, tbl[i].per, tbl[i].hi);
            check1($sformatf("tbl%0d.pwm", i),  pwm_out,      tbl[i].pwm);
            check1($sformatf("tbl%0d.ps", i),   period_start, tbl[i].ps);
            check1($sformatf("tbl%0d.busy", i), busy,         tbl[i].busy);
            check1($sformatf("tbl%0d.err", i),  cfg_err,      tbl[i].err);
        end

        // Mid-period reconfiguration 4/1 -> 8/6 loaded at cnt=1.
        do_reset();
        sh = '0;
        tick(1, 1, 8'd4, 8'd1); check_model("reconf"); sh = {sh[10:0], pwm_out};
        tick(1, 0, 8'd0, 8'd0); check_model("reconf"); sh = {sh[10:0], pwm_out};
        tick(1, 1, 8'd8, 8'd6); check_model("reconf"); sh = {sh[10:0], pwm_out};
        for (int i = 0; i < 9; i++) begin
            tick(1, 0, 8'd0, 8'd0); check_model("reconf"); sh = {sh[10:0], pwm_out};
        end
        check_int("reconf.pattern", int'(sh), int'(12'b1000_1111_1100));

        // 25% duty measured in time between period_start pulses.
        do_reset();
        tick(0, 1, 8'd4, 8'd1);
        t0 = -1.0; t_fall = -1.0; t1 = -1.0;
        for (int i = 0; i < 9; i++) begin
            tick(1, 0, 8'd0, 8'd0);
            check_model("duty25");
            if (period_start && t0 < 0.0) t0 = $realtime;
            else if (t0 >= 0.0 && t_fall < 0.0 && !pwm_out) t_fall = $realtime;
            else if (period_start && t_fall >= 0.0 && t1 < 0.0) t1 = $realtime;
        end
        if (t1 > t0 && t0 >= 0.0)
            check_int("duty25.ratio", int'(100.0 * (t_fall - t0) / (t1 - t0)), 25);
        else
            check_int("duty25.edges_seen", 0, 1);

        // Illegal load while running: one cfg_err pulse, waveform unchanged.
        tick(1, 1, 8'd1, 8'd3); check_model("illegal");
        check1("illegal.err", cfg_err, 1'b1);
        run(8, "illegal");

        // Saturation: high >= period gives a constant 1.
        do_reset();
        tick(0, 1, 8'd5, 8'd9);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 8'd0, 8'd0);
            check_model("sat");
            check1("sat.pwm_one", pwm_out, 1'b1);
        end

        // Zero high time gives a constant 0.
        do_reset();
        tick(0, 1, 8'd3, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 8'd0, 8'd0);
            check_model("zero");
            check1("zero.pwm_zero", pwm_out, 1'b0);
        end

        // Drain: 6/3, en dropped at cnt=2, period completes then IDLE.
        do_reset();
        tick(0, 1, 8'd6, 8'd3);
        run(3, "drain");
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 8'd0, 8'd0);
            check_model("drain");
        end
        check1("drain.busy_low", busy, 1'b0);

        // Drain with en re-asserted at cnt=4: next period is seamless.
        do_reset();
        tick(0, 1, 8'd6, 8'd3);
        run(3, "redrain");
        tick(0, 0, 8'd0, 8'd0); check_model("redrain");
        tick(0, 0, 8'd0, 8'd0); check_model("redrain");
        run(2, "redrain");
        check1("redrain.ps", period_start, 1'b1);
        run(6, "redrain");

        // Asynchronous reset mid high phase, then restart at 50%.
        do_reset();
        tick(1, 0, 8'd0, 8'd0); check_model("areset.pre");
        #2 rst_n = 1'b0;
        #1;
        check1("areset.pwm",  pwm_out,      1'b0);
        check1("areset.busy", busy,         1'b0);
        check1("areset.ps",   period_start, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(6, "areset.post");

        // Randomized run against the model.
        do_reset();
        en_r = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            if ($urandom_range(0, 7) == 0)
                tick(en_r, 1'b1, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 14)));
            else
                tick(en_r, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
